// File: rtl/reset_ctrl_pkg.sv
// reset_ctrl_pkg: shared state encoding and restart-counter width for reset_ctrl
package reset_ctrl_pkg;
    typedef enum logic [1:0] {HOLD, RUN, TRAPPED, WAIT} state_t;
    localparam int COUNT_W = 8;
endpackage

// File: rtl/debounce.sv
// debounce: 2-FF synchroniser plus consecutive-sample counter for an active-low button
module debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_db
);
    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]   sync;
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= 2'b11;
            btn_db <= 1'b1;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], btn_n};
            if (sync[1] == btn_db) begin
                cnt <= '0;
            end else if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end
endmodule

// File: rtl/reset_ctrl.sv
// reset_ctrl: button/trap reset sequencer; define TRAP_AUTORESTART_EN for timed restart after a trap
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 16,
    parameter int RESTART_CYCLES  = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_n,
    input  logic               trap,
    output logic               power_on_reset,
    output logic               running,
    output logic               trapped,
    output logic [COUNT_W-1:0] reset_count
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || RESTART_CYCLES < 1) begin : g_param_check
        $error("reset_ctrl: cycle parameters must be >= 1");
    end

    state_t        state, next;
    logic          btn_db, btn_prev, press;
    logic [HW-1:0] hold_cnt;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_n),
        .btn_db(btn_db)
    );

    assign press = btn_prev & ~btn_db;

`ifdef TRAP_AUTORESTART_EN
    localparam int RW = $clog2(RESTART_CYCLES + 1);
    logic [RW-1:0] wait_cnt;
    logic          restart_done;
    assign restart_done = wait_cnt == RW'(RESTART_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) wait_cnt <= '0;
        else       wait_cnt <= (state == WAIT) ? wait_cnt + RW'(1) : '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= HOLD;
        else       state <= next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev    <= 1'b1;
            hold_cnt    <= HW'(HOLD_CYCLES);
            reset_count <= '0;
        end else begin
            btn_prev <= btn_db;
            // countdown only runs once the button is released; held button keeps reloading
            hold_cnt <= (state != HOLD || !btn_db) ? HW'(HOLD_CYCLES) : hold_cnt - HW'(1);
            if (state != HOLD && next == HOLD && reset_count != '1)
                reset_count <= reset_count + COUNT_W'(1);
        end
    end

    always_comb begin
        next = state;
        case (state)
            HOLD:    next = (btn_db && hold_cnt <= HW'(1)) ? RUN : HOLD;
            RUN:     next = press ? HOLD : trap ? TRAPPED : RUN;
`ifdef TRAP_AUTORESTART_EN
            TRAPPED: next = press ? HOLD : WAIT;
            WAIT:    next = (press || restart_done) ? HOLD : WAIT;
`else
            TRAPPED: next = press ? HOLD : TRAPPED;
`endif
            default: next = HOLD;
        endcase
    end

    always_comb begin
        power_on_reset = state == HOLD;
        running        = state == RUN;
        trapped        = state == TRAPPED || state == WAIT;
    end
endmodule
